// File: rtl/ps2_kbd_receiver.sv
// ps2_kbd_receiver
//   Receives PS/2 keyboard frames clocked by the device and presents each good
//   byte on a parallel bus with a one-cycle strobe. Both PS/2 lines are
//   synchronised, ps2c is de-glitched, frames are checked for odd parity and
//   stop bit, and stalled partial frames are dropped after a timeout.
//
// Ports
//   clk        in   system clock, rising-edge
//   rst        in   asynchronous active-high reset
//   ps2c       in   PS/2 clock from device (async, idle high)
//   ps2d       in   PS/2 data from device (async, idle high)
//   ready      out  one-cycle strobe: data holds a freshly received byte
//   data       out  last good byte, held between strobes
//   frame_err  out  one-cycle strobe: frame failed parity or stop check
module ps2_kbd_receiver #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       ready,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam int unsigned FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [FCW-1:0] FiltLast = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] ToLast   = TCW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRecv  = 2'd1;
    localparam logic [1:0] StCheck = 2'd2;

    // Synchronisers
    logic           c_s1_q, c_s2_q, d_s1_q, d_s2_q;
    // Clock filter
    logic           fc_q, fc_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fe_q, fe_d;
    // Frame state
    logic [1:0]     state_q, state_d;
    logic [3:0]     bitcnt_q, bitcnt_d;
    // sr[9] = stop, sr[8] = parity, sr[7:0] = byte once all bits are in
    logic [9:0]     sr_q, sr_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    // Outputs
    logic           ready_q, ready_d;
    logic [7:0]     data_q, data_d;
    logic           err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_s1_q <= 1'b1;
            c_s2_q <= 1'b1;
            d_s1_q <= 1'b1;
            d_s2_q <= 1'b1;
        end else begin
            c_s1_q <= ps2c;
            c_s2_q <= c_s1_q;
            d_s1_q <= ps2d;
            d_s2_q <= d_s1_q;
        end
    end

    // fc follows the synced clock only after FILTER_LEN consecutive samples
    // disagree with it; any agreeing sample restarts the run.
    always_comb begin
        fc_d       = fc_q;
        filt_cnt_d = '0;
        if (c_s2_q != fc_q) begin
            if (filt_cnt_q == FiltLast) begin
                fc_d = c_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        fe_d = fc_q & ~fc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_q       <= 1'b1;
            filt_cnt_q <= '0;
            fe_q       <= 1'b0;
        end else begin
            fc_q       <= fc_d;
            filt_cnt_q <= filt_cnt_d;
            fe_q       <= fe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        to_cnt_d = '0;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        data_d   = data_q;
        unique case (state_q)
            StIdle: begin
                bitcnt_d = 4'd0;
                if (fe_q && !d_s2_q) begin
                    state_d  = StRecv;
                    bitcnt_d = 4'd1;
                end
            end
            StRecv: begin
                if (fe_q) begin
                    sr_d     = {d_s2_q, sr_q[9:1]};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd10) begin
                        state_d = StCheck;
                    end
                end else if (to_cnt_q == ToLast) begin
                    state_d  = StIdle;
                    bitcnt_d = 4'd0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if ((^sr_q[8:0]) && sr_q[9]) begin
                    ready_d = 1'b1;
                    data_d  = sr_q[7:0];
                end else begin
                    err_d = 1'b1;
                end
                state_d  = StIdle;
                bitcnt_d = 4'd0;
            end
            default: begin
                state_d  = StIdle;
                bitcnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            bitcnt_q <= 4'd0;
            sr_q     <= '0;
            to_cnt_q <= '0;
            ready_q  <= 1'b0;
            data_q   <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sr_q     <= sr_d;
            to_cnt_q <= to_cnt_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign ready     = ready_q;
    assign data      = data_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_kbd_receiver.sv
module tb_ps2_kbd_receiver;

    localparam int FL   = 8;
    localparam int TO   = 500;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       ready;
    logic [7:0] data;
    logic       frame_err;

    ps2_kbd_receiver #(
        .FILTER_LEN (FL),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2c     (ps2c),
        .ps2d     (ps2d),
        .ready    (ready),
        .data     (data),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         passed = 0;
    int         total = 0;
    int         ready_cnt = 0;
    int         err_cnt = 0;
    int         overlap_cnt = 0;
    int         wide_cnt = 0;
    int         last_pulse_cyc = 0;
    int         fall_cyc = 0;
    logic [7:0] ready_data = 8'h00;
    logic       ready_prev = 1'b0;
    logic       err_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ready) begin
                ready_cnt++;
                ready_data = data;
                last_pulse_cyc = cyc;
            end
            if (frame_err) begin
                err_cnt++;
                last_pulse_cyc = cyc;
            end
            if (ready && frame_err) overlap_cnt++;
            if ((ready && ready_prev) || (frame_err && err_prev)) wide_cnt++;
        end
        ready_prev = ready;
        err_prev   = frame_err;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Data changes while ps2c is high; optional short glitches in both phases.
    task automatic send_bit(input logic b, input logic glitch);
        @(negedge clk);
        ps2d = b;
        if (glitch) begin
            wait_clk(10); ps2c = 1'b0; wait_clk(3); ps2c = 1'b1; wait_clk(HALF - 13);
        end else begin
            wait_clk(HALF);
        end
        ps2c = 1'b0;
        fall_cyc = cyc;
        if (glitch) begin
            wait_clk(12); ps2c = 1'b1; wait_clk(3); ps2c = 1'b0; wait_clk(HALF - 15);
        end else begin
            wait_clk(HALF);
        end
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input logic glitch);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
        ps2d = 1'b1;
        wait_clk(HALF);
    endtask

    typedef struct {
        logic [7:0] byte_v;
        logic       par;
        logic       stop;
        logic       glitch;
        int         exp_ready;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    int r0, e0, lat;

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1, 0, 8'h1C};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1, 0, 8'hF0};
        vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1, 0, 8'h1C};
        vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b0, 0, 1, 8'h1C};  // bad parity
        vecs[4] = '{8'h29, 1'b0, 1'b0, 1'b0, 0, 1, 8'h1C};  // bad stop
        vecs[5] = '{8'h29, 1'b0, 1'b1, 1'b0, 1, 0, 8'h29};
        vecs[6] = '{8'hE0, 1'b0, 1'b1, 1'b1, 1, 0, 8'hE0};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b0, 1, 0, 8'h00};
        vecs[8] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1, 0, 8'hFF};

        wait_clk(3);
        check("reset ready", int'(ready), 0);
        check("reset data", int'(data), 8'h00);
        check("reset frame_err", int'(frame_err), 0);
        rst = 1'b0;
        wait_clk(50);
        check("idle after reset ready count", ready_cnt + err_cnt, 0);

        for (int i = 0; i < 9; i++) begin
            r0 = ready_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].byte_v, vecs[i].par, vecs[i].stop, vecs[i].glitch);
            wait_clk(20);
            check($sformatf("vec%0d ready pulses", i), ready_cnt - r0, vecs[i].exp_ready);
            check($sformatf("vec%0d err pulses", i), err_cnt - e0, vecs[i].exp_err);
            check($sformatf("vec%0d data", i), int'(data), int'(vecs[i].exp_data));
            if (vecs[i].exp_ready == 1)
                check($sformatf("vec%0d data at strobe", i), int'(ready_data),
                      int'(vecs[i].exp_data));
            lat = last_pulse_cyc - fall_cyc;
            check($sformatf("vec%0d latency %0d in window", i, lat),
                  int'(lat >= FL + 2 && lat <= FL + 6), 1);
        end

        // Partial frame stalled past the timeout, then a stray idle '1' bit.
        r0 = ready_cnt;
        e0 = err_cnt;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        wait_clk(TO + 200);
        check("timeout no pulse", (ready_cnt - r0) + (err_cnt - e0), 0);
        send_bit(1'b1, 1'b0);
        wait_clk(HALF);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        wait_clk(20);
        check("after timeout ready pulses", ready_cnt - r0, 1);
        check("after timeout err pulses", err_cnt - e0, 0);
        check("after timeout data", int'(data), 8'h5A);

        // Reset mid-frame.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(2);
        check("mid-frame rst data", int'(data), 8'h00);
        check("mid-frame rst ready", int'(ready), 0);
        check("mid-frame rst frame_err", int'(frame_err), 0);
        rst = 1'b0;
        wait_clk(20);
        r0 = ready_cnt;
        e0 = err_cnt;
        send_frame(8'h66, 1'b1, 1'b1, 1'b0);
        wait_clk(20);
        check("after rst ready pulses", ready_cnt - r0, 1);
        check("after rst err pulses", err_cnt - e0, 0);
        check("after rst data", int'(data), 8'h66);

        check("ready/frame_err overlap", overlap_cnt, 0);
        check("strobe wider than 1 cycle", wide_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
